// File: rtl/keypad_pkg.sv
// Package for the keypad scanner.
// Holds the shared scanner state type, the column constants and a one-hot
// to index helper that the decoder uses.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    localparam int unsigned NUM_COLS = 4;
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b0001;

    // Index of the set bit in a 4-bit one-hot vector (highest set bit wins).
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational keypad decoder.
// Maps a one-hot (row, col) pair to a 4-bit key code: key = row_index*4 + col_index.
// Ports:
//   row - one-hot row of the pressed key
//   col - one-hot column of the pressed key
//   key - decoded 4-bit key value
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [3:0]          row,
    input  logic [NUM_COLS-1:0] col,
    output logic [3:0]          key
);

    always_comb begin
        key = {onehot_index(row), onehot_index(col)};
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Drives one column at a time, samples the synchronized rows, debounces a
// single key press and release, and reports the decoded key.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-low reset
//   rows      - raw row inputs, active-high, asynchronous to clk
//   col       - one-hot column drive, active-high
//   key       - decoded value of the last accepted key
//   key_valid - one-cycle pulse when a new key is accepted
//   key_held  - high while the accepted key is held or its release is debounced
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          rows,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key,
    output logic                key_valid,
    output logic                key_held
);

    localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t          state_q, state_d;
    logic [3:0]           rows_meta_q, rows_s_q;
    logic [NUM_COLS-1:0]  col_q, col_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           row_l_q, row_l_d;
    logic [3:0]           key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q, key_held_d;

    logic [3:0]           dec_key;
    logic [NUM_COLS-1:0]  col_next;
    logic                 rows_onehot;
    logic                 row_l_present;

    // col_q is frozen outside SCAN, so it doubles as the latched column.
    keypad_decoder u_decoder (
        .row (row_l_q),
        .col (col_q),
        .key (dec_key)
    );

    always_comb begin
        col_next      = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
        rows_onehot   = (rows_s_q != '0) && ((rows_s_q & (rows_s_q - 4'd1)) == '0);
        row_l_present = (rows_s_q & row_l_q) != '0;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        row_l_d     = row_l_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (rows_onehot) begin
                        row_l_d = rows_s_q;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows_s_q != row_l_q) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = col_next;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    key_d       = dec_key;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!row_l_present) begin
                    cnt_d   = '0;
                    state_d = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (row_l_present) begin
                    state_d = PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    key_held_d = 1'b0;
                    state_d    = SCAN;
                    cnt_d      = '0;
                    col_d      = col_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            rows_meta_q <= '0;
            rows_s_q    <= '0;
            col_q       <= COL_RESET;
            cnt_q       <= '0;
            row_l_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            // Two-flop synchronizer on the raw rows.
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            row_l_q     <= row_l_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with a behavioural keypad and reference model.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DB = 8;

    localparam int M_SCAN = 0;
    localparam int M_DB   = 1;
    localparam int M_PR   = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    int total  = 0;
    int bad    = 0;
    int pulses = 0;
    logic prev_v = 1'b0;

    // Physical keypad: press_map[c] is the set of rows pressed in column c.
    logic [3:0] press_map [4];
    logic       force_en;
    logic [3:0] force_val;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_row, m_key;
    int         m_mode, m_cidx, m_cnt;
    logic       m_valid, m_held;

    typedef struct {
        logic       rst_n;
        logic [3:0] rows;
        logic [3:0] col;
        logic [3:0] key;
        logic       valid;
        logic       held;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [3:0] keypad_rows(input logic [3:0] c);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (c[i] === 1'b1) r = r | press_map[i];
        end
        return r;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [3:0] key_of(input int r, input int c);
        return 4'(r * 4 + c);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of the reference behaviour, using the rows value seen at this edge.
    task automatic model_step(input logic rst_n, input logic [3:0] r);
        logic [3:0] rs;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_row = '0; m_key = '0;
            m_mode = M_SCAN; m_cidx = 0; m_cnt = 0;
            m_valid = 1'b0; m_held = 1'b0;
            return;
        end
        rs = m_s2;
        m_valid = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (m_cnt == SC - 1) begin
                    m_cnt = 0;
                    if ($countones(rs) == 1) begin
                        m_row  = rs;
                        m_mode = M_DB;
                    end else begin
                        m_cidx = (m_cidx + 1) % 4;
                    end
                end else begin
                    m_cnt++;
                end
            end
            M_DB: begin
                if (rs != m_row) begin
                    m_mode = M_SCAN; m_cnt = 0; m_cidx = (m_cidx + 1) % 4;
                end else if (m_cnt == DB - 1) begin
                    m_mode  = M_PR;
                    m_key   = key_of(idx_of(m_row), m_cidx);
                    m_valid = 1'b1;
                    m_held  = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            M_PR: begin
                if ((rs & m_row) == 0) begin
                    m_cnt = 0; m_mode = M_REL;
                end
            end
            default: begin
                if ((rs & m_row) != 0) begin
                    m_mode = M_PR;
                end else if (m_cnt == DB - 1) begin
                    m_held = 1'b0; m_mode = M_SCAN; m_cnt = 0; m_cidx = (m_cidx + 1) % 4;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = r;
    endtask

    task automatic tick();
        logic [3:0] m_col;
        rows = force_en ? force_val : keypad_rows(col);
        @(posedge clk);
        model_step(reset, rows);
        #1;
        m_col = 4'b0001 << m_cidx;
        check("cycle", {col, key, key_valid, key_held}, {m_col, m_key, m_valid, m_held});
        if (key_valid === 1'b1) begin
            pulses++;
            check("no_double_pulse", prev_v, 1'b0);
        end
        prev_v = key_valid;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_keys();
        for (int i = 0; i < 4; i++) press_map[i] = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        run(n);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] seen;
        int         reached;
        one = 4'b0001;
        reset = 1'b0;
        rows = '0;
        force_en = 1'b1;
        force_val = 4'b0100;
        clear_keys();

        // Reset and free-running scan vectors
        for (int k = 0; k < 20; k++) begin
            if (k < 3) begin
                vecs[k] = '{rst_n: 1'b0, rows: 4'b0100, col: 4'b0001, key: 4'h0, valid: 1'b0, held: 1'b0};
            end else begin
                vecs[k] = '{rst_n: 1'b1, rows: 4'b0000, col: one << (((k - 2) / 4) % 4),
                            key: 4'h0, valid: 1'b0, held: 1'b0};
            end
        end
        for (int k = 0; k < 20; k++) begin
            reset = vecs[k].rst_n;
            force_val = vecs[k].rows;
            tick();
            check("vec", {col, key, key_valid, key_held},
                  {vecs[k].col, vecs[k].key, vecs[k].valid, vecs[k].held});
        end

        // Clean press on row 0100 / col 0010
        force_en = 1'b0;
        force_val = '0;
        do_reset(2);
        press_map[1] = 4'b0100;
        pulses = 0;
        run(40);
        check("clean_pulses", pulses, 1);
        check("clean_key", key, key_of(2, 1));
        check("clean_held", key_held, 1'b1);
        check("clean_col", col, 4'b0010);
        clear_keys();
        run(40);
        check("clean_released", key_held, 1'b0);
        check("clean_no_repulse", pulses, 1);

        // Bouncing press and bouncing release
        do_reset(2);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            press_map[1] = ($urandom % 2) ? 4'b0100 : 4'b0000;
            tick();
        end
        check("bounce_quiet", pulses, 0);
        press_map[1] = 4'b0100;
        run(40);
        check("bounce_pulses", pulses, 1);
        check("bounce_key", key, key_of(2, 1));
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            press_map[1] = ($urandom % 2) ? 4'b0100 : 4'b0000;
            tick();
            check("release_bounce_held", key_held, 1'b1);
        end
        clear_keys();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("release_settle_held", key_held, 1'b1);
        end
        run(40);
        check("release_done", key_held, 1'b0);
        check("release_no_pulse", pulses, 0);

        // Multi-row press is ignored and scanning continues
        do_reset(2);
        press_map[0] = 4'b1010;
        pulses = 0;
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | col;
        end
        check("multirow_pulses", pulses, 0);
        check("multirow_scan", seen, 4'hF);
        clear_keys();

        // One-hot row lasting 3 cycles aborts debounce
        force_en = 1'b1;
        force_val = '0;
        do_reset(2);
        pulses = 0;
        tick();
        force_val = 4'b0001;
        run(3);
        force_val = '0;
        run(2);
        check("short_col_frozen", col, 4'b0001);
        tick();
        check("short_scan_resume", col, 4'b0010);
        run(30);
        check("short_pulses", pulses, 0);
        force_en = 1'b0;

        // Rollover ignored, then re-press of another key
        do_reset(2);
        press_map[1] = 4'b0100;
        run(40);
        pulses = 0;
        press_map[3] = 4'b0001;
        run(30);
        check("rollover_pulses", pulses, 0);
        check("rollover_key", key, key_of(2, 1));
        clear_keys();
        run(40);
        check("rollover_release", key_held, 1'b0);
        press_map[3] = 4'b0001;
        pulses = 0;
        run(40);
        check("repress_pulses", pulses, 1);
        check("repress_key", key, key_of(0, 3));
        clear_keys();
        run(30);

        // Reset during debounce
        do_reset(2);
        press_map[1] = 4'b0100;
        reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            tick();
            if (m_mode == M_DB) reached = 1;
        end
        check("reach_debounce", reached, 1);
        reset = 1'b0;
        run(2);
        check("midreset_outputs", {col, key, key_valid, key_held}, {4'b0001, 4'h0, 1'b0, 1'b0});
        clear_keys();
        reset = 1'b1;
        pulses = 0;
        run(40);
        check("midreset_no_stale", pulses, 0);

        // Randomized presses checked cycle by cycle against the model
        for (int t = 0; t < 20; t++) begin
            int r, c;
            logic [3:0] rb;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            rb = one << r;
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) begin
                press_map[c] = ($urandom % 2) ? rb : 4'b0000;
                tick();
            end
            press_map[c] = rb;
            run($urandom_range(20, 60));
            if ($urandom % 4 == 0) begin
                press_map[$urandom_range(0, 3)] |= (one << $urandom_range(0, 3));
                run(10);
            end
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) begin
                press_map[c] = ($urandom % 2) ? rb : 4'b0000;
                tick();
            end
            clear_keys();
            run($urandom_range(10, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
